st7735r_cmd_ctrl: RTL

- Sequences the pixel-write datapath behind the SPI slave receiver in the SPI-to-HDMI bridge.
- Consumes deserialized bytes tagged with D/C.
- Decodes the ST7735R command subset: NOP, SWRESET, DISPOFF, DISPON, CASET, RASET, RAMWR.
- Maintains the column/row address window and emits framebuffer pixel writes with (x,y) coordinates and RGB565 data.

---
 rtl/st7735r_pkg.sv | 26 ++
 rtl/st7735r_cmd_ctrl_if.sv | 27 ++
 rtl/st7735r_addr_cnt.sv | 37 +++
 rtl/st7735r_cmd_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/st7735r_pkg.sv
// Shared opcodes, FSM state type and pixel type for the ST7735R command controller.
package st7735r_pkg;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_RASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_SKIP
  } state_t;

  typedef logic [15:0] rgb565_t;

  function automatic logic [15:0] clamp_coord(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/st7735r_cmd_ctrl_if.sv
// Byte-in / pixel-out bundle between the SPI receiver, the controller and the framebuffer.
interface st7735r_cmd_ctrl_if
  import st7735r_pkg::*;
#(
  parameter int unsigned COORD_W = 10
);
  logic               i_cs_n;
  logic               i_byte_valid;
  logic [7:0]         i_byte;
  logic               i_dc;
  logic               o_pix_valid;
  logic [COORD_W-1:0] o_pix_x;
  logic [COORD_W-1:0] o_pix_y;
  rgb565_t            o_pix_data;
  logic               o_disp_on;
  logic               o_cmd_unknown;

  modport master (
    output i_cs_n, i_byte_valid, i_byte, i_dc,
    input  o_pix_valid, o_pix_x, o_pix_y, o_pix_data, o_disp_on, o_cmd_unknown
  );

  modport slave (
    input  i_cs_n, i_byte_valid, i_byte, i_dc,
    output o_pix_valid, o_pix_x, o_pix_y, o_pix_data, o_disp_on, o_cmd_unknown
  );
endinterface

// File: rtl/st7735r_addr_cnt.sv
// Framebuffer address counter: loads the window origin, then walks the window raster-order with wrap.
module st7735r_addr_cnt #(
  parameter int unsigned COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] xs,
  input  logic [COORD_W-1:0] xe,
  input  logic [COORD_W-1:0] ys,
  input  logic [COORD_W-1:0] ye,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= xs;
      y <= ys;
    end else if (step) begin
      if (x < xe) begin
        x <= x + ONE;
      end else if (y < ye) begin
        x <= xs;
        y <= y + ONE;
      end else begin
        x <= xs;
        y <= ys;
      end
    end
  end
endmodule

// File: rtl/st7735r_cmd_ctrl.sv
// ST7735R command decoder: tracks the address window and turns RAMWR data into framebuffer pixel writes.
module st7735r_cmd_ctrl
  import st7735r_pkg::*;
#(
  parameter int unsigned WIDTH   = 160,
  parameter int unsigned HEIGHT  = 128,
  parameter int unsigned COORD_W = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  st7735r_cmd_ctrl_if.slave  bus
);
  localparam logic [15:0]        X_MAX  = 16'(WIDTH - 1);
  localparam logic [15:0]        Y_MAX  = 16'(HEIGHT - 1);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

  state_t             state;
  logic [1:0]         arg_idx;
  logic               arg_row;
  logic [23:0]        arg_sr;
  logic [7:0]         pix_hi;
  logic [COORD_W-1:0] xs, xe, ys, ye;
  logic [COORD_W-1:0] cnt_x, cnt_y;
  logic               cmd_stb, dat_stb, cnt_load, cnt_step;
  logic [15:0]        lim, s_c, e_c;
  logic [COORD_W-1:0] win_s, win_e;

  logic               pix_valid, disp_on, cmd_unknown;
  logic [COORD_W-1:0] pix_x, pix_y;
  rgb565_t            pix_data;

  always_comb begin
    cmd_stb  = bus.i_byte_valid & ~bus.i_cs_n & ~bus.i_dc;
    dat_stb  = bus.i_byte_valid & ~bus.i_cs_n &  bus.i_dc;
    cnt_load = cmd_stb && (bus.i_byte == OP_RAMWR);
    cnt_step = dat_stb && (state == ST_PIX_LO);
  end

  // The 4th argument byte completes E, so clamping works on the live byte, not the shift register.
  always_comb begin
    lim   = arg_row ? Y_MAX : X_MAX;
    s_c   = clamp_coord(arg_sr[23:8], lim);
    e_c   = clamp_coord({arg_sr[7:0], bus.i_byte}, lim);
    if (e_c < s_c) e_c = s_c;
    win_s = s_c[COORD_W-1:0];
    win_e = e_c[COORD_W-1:0];
  end

  st7735r_addr_cnt #(.COORD_W(COORD_W)) u_addr_cnt (
    .clk  (i_clk),
    .rst  (i_rst),
    .load (cnt_load),
    .step (cnt_step),
    .xs   (xs),
    .xe   (xe),
    .ys   (ys),
    .ye   (ye),
    .x    (cnt_x),
    .y    (cnt_y)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      arg_idx     <= '0;
      arg_row     <= 1'b0;
      arg_sr      <= '0;
      pix_hi      <= '0;
      xs          <= '0;
      xe          <= X_LAST;
      ys          <= '0;
      ye          <= Y_LAST;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      disp_on     <= 1'b0;
      cmd_unknown <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      cmd_unknown <= 1'b0;
      if (bus.i_cs_n) begin
        state <= ST_IDLE;
      end else if (cmd_stb) begin
        case (bus.i_byte)
          OP_NOP: state <= ST_IDLE;
          OP_SWRESET: begin
            xs      <= '0;
            xe      <= X_LAST;
            ys      <= '0;
            ye      <= Y_LAST;
            disp_on <= 1'b0;
            state   <= ST_IDLE;
          end
          OP_DISPOFF: begin
            disp_on <= 1'b0;
            state   <= ST_IDLE;
          end
          OP_DISPON: begin
            disp_on <= 1'b1;
            state   <= ST_IDLE;
          end
          OP_CASET, OP_RASET: begin
            arg_row <= (bus.i_byte == OP_RASET);
            arg_idx <= '0;
            state   <= ST_ARG;
          end
          OP_RAMWR: state <= ST_PIX_HI;
          default: begin
            cmd_unknown <= 1'b1;
            state       <= ST_SKIP;
          end
        endcase
      end else if (dat_stb) begin
        case (state)
          ST_ARG: begin
            if (arg_idx == 2'd3) begin
              if (arg_row) begin
                ys <= win_s;
                ye <= win_e;
              end else begin
                xs <= win_s;
                xe <= win_e;
              end
              state <= ST_IDLE;
            end else begin
              arg_sr  <= {arg_sr[15:0], bus.i_byte};
              arg_idx <= arg_idx + 2'd1;
            end
          end
          ST_PIX_HI: begin
            pix_hi <= bus.i_byte;
            state  <= ST_PIX_LO;
          end
          ST_PIX_LO: begin
            pix_data  <= {pix_hi, bus.i_byte};
            pix_x     <= cnt_x;
            pix_y     <= cnt_y;
            pix_valid <= 1'b1;
            state     <= ST_PIX_HI;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_pix_valid   = pix_valid;
  assign bus.o_pix_x       = pix_x;
  assign bus.o_pix_y       = pix_y;
  assign bus.o_pix_data    = pix_data;
  assign bus.o_disp_on     = disp_on;
  assign bus.o_cmd_unknown = cmd_unknown;
endmodule
